// File: rtl/wb_trap_commit_pkg.sv
// wb_trap_commit_pkg: exception pack, CSR addresses, privilege encodings and trap FSM states.
// Building with TRAP_SDELEG_EN adds S-mode delegation (medeleg, stvec, sepc, scause, stval, SPP/SPIE/SIE).
package ExceptStruct;

    typedef struct packed {
        logic        except;
        logic [63:0] epc;
        logic [63:0] ecause;
        logic [63:0] etval;
    } ExceptPack;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEDELEG = 12'h302;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_STVEC   = 12'h105;
    localparam logic [11:0] CSR_SEPC    = 12'h141;
    localparam logic [11:0] CSR_SCAUSE  = 12'h142;
    localparam logic [11:0] CSR_STVAL   = 12'h143;

    localparam logic [1:0] PRIV_U = 2'd0;
    localparam logic [1:0] PRIV_S = 2'd1;
    localparam logic [1:0] PRIV_M = 2'd3;

    localparam int MS_SIE  = 1;
    localparam int MS_MIE  = 3;
    localparam int MS_SPIE = 5;
    localparam int MS_MPIE = 7;
    localparam int MS_SPP  = 8;
    localparam int MS_MPP  = 11;

    typedef enum logic [1:0] {ST_IDLE, ST_REDIRECT, ST_DRAIN} trap_state_e;

`ifdef TRAP_SDELEG_EN
    localparam bit S_EN = 1'b1;
`else
    localparam bit S_EN = 1'b0;
`endif

    // Only the M (and optionally S) interrupt-stack fields of mstatus are stored.
    localparam logic [63:0] MSTATUS_MASK = S_EN ? 64'h19aa : 64'h1888;

endpackage

// File: rtl/wb_trap_commit_csr_file.sv
// trap_csr_file: trap CSR registers, read mux, software write port and trap/return updates; owns priv.
module trap_csr_file
    import ExceptStruct::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [11:0] addr,
    input  logic [63:0] wdata,
    output logic [63:0] rdata,
    input  logic        trap_m,
    input  logic        trap_s,
    input  logic        xret_m,
    input  logic        xret_s,
    input  logic [63:0] epc,
    input  logic [63:0] ecause,
    input  logic [63:0] etval,
    output logic [1:0]  priv,
    output logic        deleg,
    output logic [63:0] mtvec_base,
    output logic [63:0] stvec_base,
    output logic [63:0] mepc,
    output logic [63:0] sepc
);
    logic [63:0] mstatus, mtvec, mcause, mtval, medeleg, stvec, scause, stval, ms_nx;
    logic [1:0]  priv_nx;

    function automatic logic hit(input logic [11:0] a);
        return we && addr == a;
    endfunction

    assign mtvec_base = {mtvec[63:2], 2'b00};
    assign stvec_base = {stvec[63:2], 2'b00};
    assign deleg = S_EN && priv <= PRIV_S && medeleg[ecause[5:0]];

    // Software write lands first; trap/return then overrides only the fields it owns.
    always_comb begin
        ms_nx = hit(CSR_MSTATUS) ? wdata : mstatus;
        priv_nx = priv;
        if (trap_m) begin
            ms_nx[MS_MPIE] = mstatus[MS_MIE];
            ms_nx[MS_MIE] = 1'b0;
            ms_nx[MS_MPP +: 2] = priv;
            priv_nx = PRIV_M;
        end else if (trap_s) begin
            ms_nx[MS_SPIE] = mstatus[MS_SIE];
            ms_nx[MS_SIE] = 1'b0;
            ms_nx[MS_SPP] = priv[0];
            priv_nx = PRIV_S;
        end else if (xret_m) begin
            ms_nx[MS_MIE] = mstatus[MS_MPIE];
            ms_nx[MS_MPIE] = 1'b1;
            ms_nx[MS_MPP +: 2] = PRIV_U;
            priv_nx = mstatus[MS_MPP +: 2];
        end else if (xret_s) begin
            ms_nx[MS_SIE] = mstatus[MS_SPIE];
            ms_nx[MS_SPIE] = 1'b1;
            ms_nx[MS_SPP] = 1'b0;
            priv_nx = {1'b0, mstatus[MS_SPP]};
        end
    end

    always_comb begin
        case (addr)
            CSR_MSTATUS: rdata = mstatus;
            CSR_MEDELEG: rdata = medeleg;
            CSR_MTVEC:   rdata = mtvec;
            CSR_MEPC:    rdata = mepc;
            CSR_MCAUSE:  rdata = mcause;
            CSR_MTVAL:   rdata = mtval;
            CSR_STVEC:   rdata = stvec;
            CSR_SEPC:    rdata = sepc;
            CSR_SCAUSE:  rdata = scause;
            CSR_STVAL:   rdata = stval;
            default:     rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            priv <= PRIV_M;
            mstatus <= '0;
            mtvec <= '0;
            mepc <= '0;
            mcause <= '0;
            mtval <= '0;
            medeleg <= '0;
            stvec <= '0;
            sepc <= '0;
            scause <= '0;
            stval <= '0;
        end else begin
            priv <= priv_nx;
            mstatus <= ms_nx & MSTATUS_MASK;
            mtvec <= hit(CSR_MTVEC) ? wdata : mtvec;
            mepc <= trap_m ? epc : hit(CSR_MEPC) ? {wdata[63:1], 1'b0} : mepc;
            mcause <= trap_m ? ecause : hit(CSR_MCAUSE) ? wdata : mcause;
            mtval <= trap_m ? etval : hit(CSR_MTVAL) ? wdata : mtval;
            medeleg <= S_EN && hit(CSR_MEDELEG) ? wdata : medeleg;
            stvec <= S_EN && hit(CSR_STVEC) ? wdata : stvec;
            sepc <= trap_s ? epc : S_EN && hit(CSR_SEPC) ? {wdata[63:1], 1'b0} : sepc;
            scause <= trap_s ? ecause : S_EN && hit(CSR_SCAUSE) ? wdata : scause;
            stval <= trap_s ? etval : S_EN && hit(CSR_STVAL) ? wdata : stval;
        end
    end
endmodule

// File: rtl/wb_trap_commit.sv
// wb_trap_commit: WB-stage trap/xret commit, privilege owner, PC redirect and timed flush.
module wb_trap_commit
    import ExceptStruct::*;
#(
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [63:0] RESET_PC     = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        valid_wb,
    input  ExceptPack   except_wb,
    input  logic        mret_wb,
    input  logic        sret_wb,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [63:0] csr_wdata,
    output logic [63:0] csr_rdata,
    output logic [1:0]  priv,
    output logic        redirect_valid_o,
    output logic [63:0] redirect_pc_o,
    output logic        flush_o,
    output logic        busy_o
);
    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    trap_state_e   state;
    logic [CW-1:0] cnt;
    logic          commit, trap, deleg, trap_m, trap_s, xret_m, xret_s, go;
    logic [63:0]   mtvec_base, stvec_base, mepc, sepc, target;

    // Returns that are illegal at the current privilege retire as no-ops.
    assign commit = state == ST_IDLE && !stall && valid_wb;
    assign trap = commit && except_wb.except;
    assign xret_m = commit && !except_wb.except && mret_wb && priv == PRIV_M;
    assign xret_s = S_EN && commit && !except_wb.except && !mret_wb && sret_wb && priv != PRIV_U;
    assign trap_m = trap && !deleg;
    assign trap_s = trap && deleg;
    assign go = trap || xret_m || xret_s;
    assign target = trap_s ? stvec_base : trap_m ? mtvec_base : xret_m ? mepc : sepc;

    assign busy_o = state != ST_IDLE && !rst;
    assign flush_o = busy_o;
    assign redirect_valid_o = state == ST_REDIRECT && !rst;

    trap_csr_file u_csr (
        .clk        (clk),
        .rst        (rst),
        .we         (csr_we),
        .addr       (csr_addr),
        .wdata      (csr_wdata),
        .rdata      (csr_rdata),
        .trap_m     (trap_m),
        .trap_s     (trap_s),
        .xret_m     (xret_m),
        .xret_s     (xret_s),
        .epc        (except_wb.epc),
        .ecause     (except_wb.ecause),
        .etval      (except_wb.etval),
        .priv       (priv),
        .deleg      (deleg),
        .mtvec_base (mtvec_base),
        .stvec_base (stvec_base),
        .mepc       (mepc),
        .sepc       (sepc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt <= '0;
            redirect_pc_o <= RESET_PC;
        end else begin
            if (go) redirect_pc_o <= target;
            case (state)
                ST_IDLE: state <= go ? ST_REDIRECT : ST_IDLE;
                ST_REDIRECT: begin
                    state <= FLUSH_CYCLES > 1 ? ST_DRAIN : ST_IDLE;
                    cnt <= CW'(FLUSH_CYCLES - 1);
                end
                ST_DRAIN: begin
                    cnt <= cnt - CW'(1);
                    state <= cnt == CW'(1) ? ST_IDLE : ST_DRAIN;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_trap_commit.sv
// tb_wb_trap_commit: vector table plus hand sequences; redirect targets scoreboarded through a queue.
module tb_wb_trap_commit;
    import ExceptStruct::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        valid_wb = 1'b0;
    ExceptPack   except_wb = '0;
    logic        mret_wb = 1'b0;
    logic        sret_wb = 1'b0;
    logic        csr_we = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [63:0] csr_wdata = '0;
    logic [63:0] csr_rdata, redirect_pc_o;
    logic [1:0]  priv;
    logic        redirect_valid_o, flush_o, busy_o;

    int n_tests = 0;
    int n_fail = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        bit          vld, t, m, s;
        logic [63:0] cause, epc, tval;
        bit          redir;
        logic [63:0] pc;
        logic [1:0]  pv;
        logic [63:0] ms, mepc, mc, mt;
    } vec_t;
    vec_t vt[9];

    wb_trap_commit #(.FLUSH_CYCLES(2), .RESET_PC(64'h1000)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .valid_wb         (valid_wb),
        .except_wb        (except_wb),
        .mret_wb          (mret_wb),
        .sret_wb          (sret_wb),
        .csr_we           (csr_we),
        .csr_addr         (csr_addr),
        .csr_wdata        (csr_wdata),
        .csr_rdata        (csr_rdata),
        .priv             (priv),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .flush_o          (flush_o),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic rd(input logic [11:0] a, input logic [63:0] exp, input string nm);
        csr_addr = a;
        #1;
        chk(nm, csr_rdata, exp);
    endtask

    task automatic wr(input logic [11:0] a, input logic [63:0] d);
        @(posedge clk); #1;
        csr_we = 1'b1; csr_addr = a; csr_wdata = d;
        @(posedge clk); #1;
        csr_we = 1'b0;
    endtask

    task automatic drive(input bit t, m, s, input logic [63:0] cause, epc, tval);
        valid_wb = 1'b1;
        except_wb = '{except: t, epc: epc, ecause: cause, etval: tval};
        mret_wb = m;
        sret_wb = s;
    endtask

    task automatic idle_in();
        valid_wb = 1'b0; except_wb = '0; mret_wb = 1'b0; sret_wb = 1'b0;
    endtask

    // One-cycle commit, then the strobe/flush shape over the next three cycles.
    task automatic commit(input bit vld, t, m, s, input logic [63:0] cause, epc, tval,
                          input bit redir, input logic [63:0] pc, input string nm);
        @(posedge clk); #1;
        drive(t, m, s, cause, epc, tval);
        valid_wb = vld;
        if (redir) exp_q.push_back(pc);
        @(posedge clk); #1;
        idle_in();
        @(negedge clk);
        chk($sformatf("%s_c1", nm), 64'({redirect_valid_o, flush_o, busy_o}), 64'({redir, redir, redir}));
        @(negedge clk);
        chk($sformatf("%s_c2", nm), 64'({redirect_valid_o, flush_o, busy_o}), 64'({1'b0, redir, redir}));
        @(negedge clk);
        chk($sformatf("%s_c3", nm), 64'({redirect_valid_o, flush_o, busy_o}), 64'(0));
    endtask

    always @(negedge clk) begin
        if (!rst && redirect_valid_o) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_redirect: got pc %h, required no redirect", redirect_pc_o);
            end else begin
                chk("redirect_pc", redirect_pc_o, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{1, 0, 1, 0, 0, 0, 0, 1, 64'h2000, 2'd0, 64'h88, 64'h2000, 0, 0};
        vt[1] = '{1, 1, 0, 0, 13, 64'h1004, 64'hdead, 1, 64'h8000_0100, 2'd3, 64'h80, 64'h1004, 13, 64'hdead};
        vt[2] = '{1, 0, 1, 0, 0, 0, 0, 1, 64'h1004, 2'd0, 64'h88, 64'h1004, 13, 64'hdead};
        vt[3] = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 2'd0, 64'h88, 64'h1004, 13, 64'hdead};
        vt[4] = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 2'd0, 64'h88, 64'h1004, 13, 64'hdead};
        vt[5] = '{1, 1, 0, 0, 2, 64'h3000, 64'h11, 1, 64'h8000_0100, 2'd3, 64'h80, 64'h3000, 2, 64'h11};
        vt[6] = '{1, 1, 0, 0, 3, 64'h3004, 0, 1, 64'h8000_0100, 2'd3, 64'h1800, 64'h3004, 3, 0};
        vt[7] = '{1, 0, 1, 0, 0, 0, 0, 1, 64'h3004, 2'd3, 64'h80, 64'h3004, 3, 0};
        vt[8] = '{0, 1, 0, 0, 6, 64'h7000, 0, 0, 0, 2'd3, 64'h80, 64'h3004, 3, 0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_priv", 64'(priv), 64'(3));
        chk("rst_flush", 64'({flush_o, busy_o, redirect_valid_o}), 64'(0));
        chk("rst_pc", redirect_pc_o, 64'h1000);
        rd(CSR_MTVEC, 64'h0, "rst_mtvec");
        @(posedge clk); #1;
        rst = 1'b0;

        wr(CSR_MTVEC, 64'h8000_0103);
        wr(CSR_MEPC, 64'h2000);
        wr(CSR_MSTATUS, 64'h80);
        rd(CSR_MTVEC, 64'h8000_0103, "mtvec_rb");

        for (int i = 0; i < 9; i++) begin
            commit(vt[i].vld, vt[i].t, vt[i].m, vt[i].s, vt[i].cause, vt[i].epc, vt[i].tval,
                   vt[i].redir, vt[i].pc, $sformatf("v%0d", i));
            chk($sformatf("v%0d_priv", i), 64'(priv), 64'(vt[i].pv));
            rd(CSR_MSTATUS, vt[i].ms, $sformatf("v%0d_mstatus", i));
            rd(CSR_MEPC, vt[i].mepc, $sformatf("v%0d_mepc", i));
            rd(CSR_MCAUSE, vt[i].mc, $sformatf("v%0d_mcause", i));
            rd(CSR_MTVAL, vt[i].mt, $sformatf("v%0d_mtval", i));
        end

        @(posedge clk); #1;
        drive(1, 0, 0, 5, 64'h4000, 0);
        stall = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_hold", 64'({redirect_valid_o, busy_o}), 64'(0));
            @(posedge clk);
        end
        #1;
        stall = 1'b0;
        exp_q.push_back(64'h8000_0100);
        @(posedge clk); #1;
        idle_in();
        @(negedge clk);
        chk("stall_release", 64'(redirect_valid_o), 64'(1));
        repeat (3) @(posedge clk);
        rd(CSR_MEPC, 64'h4000, "stall_mepc");

        @(posedge clk); #1;
        drive(1, 0, 0, 7, 64'h5000, 0);
        exp_q.push_back(64'h8000_0100);
        @(posedge clk); #1;
        drive(1, 0, 0, 8, 64'h6000, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        idle_in();
        @(negedge clk);
        chk("drain_done", 64'(busy_o), 64'(0));
        rd(CSR_MEPC, 64'h5000, "drain_mepc");
        rd(CSR_MCAUSE, 64'd7, "drain_mcause");

        @(posedge clk); #1;
        drive(1, 0, 0, 9, 64'h8000, 0);
        csr_we = 1'b1; csr_addr = CSR_MEPC; csr_wdata = 64'h7777;
        exp_q.push_back(64'h8000_0100);
        @(posedge clk); #1;
        idle_in();
        csr_we = 1'b0;
        repeat (3) @(posedge clk);
        rd(CSR_MEPC, 64'h8000, "collide_mepc");

        wr(CSR_MEPC, 64'h1235);
        rd(CSR_MEPC, 64'h1234, "mepc_bit0");
        rd(12'h7c0, 64'h0, "unimpl_csr");
        wr(CSR_STVEC, 64'h4444);
        rd(CSR_STVEC, S_EN ? 64'h4444 : 64'h0, "stvec_opt");

        @(posedge clk); #1;
        drive(1, 0, 0, 4, 64'h9000, 0);
        exp_q.push_back(64'h8000_0100);
        @(posedge clk); #1;
        idle_in();
        @(posedge clk); #1;
        chk("pre_rst_flush", 64'(flush_o), 64'(1));
        rst = 1'b1;
        #1;
        chk("rst_flush_drop", 64'(flush_o), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_pc2", redirect_pc_o, 64'h1000);
        chk("rst_priv2", 64'(priv), 64'(3));
        rd(CSR_MTVEC, 64'h0, "rst_mtvec2");

`ifdef TRAP_SDELEG_EN
        wr(CSR_MEDELEG, 64'h2000);
        wr(CSR_STVEC, 64'h4000_0001);
        wr(CSR_MTVEC, 64'h8000_0000);
        wr(CSR_MEPC, 64'h100);
        commit(1, 0, 1, 0, 0, 0, 0, 1, 64'h100, "s_mret");
        chk("s_mret_priv", 64'(priv), 64'(0));
        commit(1, 1, 0, 0, 13, 64'h2224, 64'h5, 1, 64'h4000_0000, "s_trap");
        chk("s_trap_priv", 64'(priv), 64'(1));
        rd(CSR_SEPC, 64'h2224, "s_sepc");
        rd(CSR_SCAUSE, 64'd13, "s_scause");
        rd(CSR_MEPC, 64'h100, "s_mepc_kept");
        commit(1, 0, 0, 1, 0, 0, 0, 1, 64'h2224, "s_sret");
        chk("s_sret_priv", 64'(priv), 64'(0));
        commit(1, 1, 0, 0, 2, 64'h3330, 0, 1, 64'h8000_0000, "s_nodeleg");
        chk("s_nodeleg_priv", 64'(priv), 64'(3));
        commit(1, 1, 0, 0, 13, 64'h4440, 0, 1, 64'h8000_0000, "s_from_m");
        chk("s_from_m_priv", 64'(priv), 64'(3));
        rd(CSR_MEPC, 64'h4440, "s_from_m_mepc");
`endif

        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
